// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl
// Mode and time-setting sequencer for the digital clock datapath.
// It owns the RUN / SET_MIN / SET_HOUR state and produces these outputs:
//   - the seconds-chain count enable
//   - a seconds clear when set mode is entered
//   - single-cycle minute/hour increment pulses, with press-and-hold auto-repeat
//   - blink blanking controls for the digit pair being set
//   - an idle timeout that returns the block to RUN
// Every output comes straight from a flop.

module clock_set_ctrl #(
  parameter int HOLD_CYC   = 50000000,
  parameter int REPEAT_CYC = 10000000,
  parameter int BLINK_CYC  = 25000000,
  parameter int TIMEOUT_S  = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic       mode_btn,
  input  logic       sel_btn,
  input  logic       up_btn,
  output logic       run_en,
  output logic       sec_clr,
  output logic       inc_min,
  output logic       inc_hour,
  output logic       blank_min,
  output logic       blank_hour,
  output logic [1:0] state
);

  // The hold/repeat counter is shared by both phases, so it is sized for the longer interval.
  localparam int HMAX   = (HOLD_CYC > REPEAT_CYC) ? HOLD_CYC : REPEAT_CYC;
  localparam int HCNT_W = $clog2(HMAX + 1);
  localparam int BCNT_W = $clog2(BLINK_CYC + 1);
  localparam int ICNT_W = $clog2(TIMEOUT_S + 1);

  localparam logic [HCNT_W-1:0] HOLD_LAST    = HCNT_W'(HOLD_CYC);
  localparam logic [HCNT_W-1:0] REPEAT_LAST  = HCNT_W'(REPEAT_CYC);
  localparam logic [BCNT_W-1:0] BLINK_LAST   = BCNT_W'(BLINK_CYC);
  localparam logic [ICNT_W-1:0] TIMEOUT_LAST = ICNT_W'(TIMEOUT_S);

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_SET_MIN  = 2'b01,
    ST_SET_HOUR = 2'b10
  } state_t;

  // Registered state
  state_t            state_r;
  logic              up_prev_r;
  logic              armed_r;      // up_btn press that is allowed to auto-repeat
  logic              rep_phase_r;  // 0: waiting out HOLD_CYC, 1: repeating every REPEAT_CYC
  logic [HCNT_W-1:0] hold_cnt_r;
  logic [BCNT_W-1:0] blink_cnt_r;
  logic              phase_off_r;
  logic [ICNT_W-1:0] idle_cnt_r;
  logic              run_en_r;
  logic              sec_clr_r;
  logic              inc_min_r;
  logic              inc_hour_r;
  logic              blank_min_r;
  logic              blank_hour_r;

  // Next-state values
  state_t            state_s;
  logic              armed_s;
  logic              rep_phase_s;
  logic [HCNT_W-1:0] hold_cnt_s;
  logic [BCNT_W-1:0] blink_cnt_s;
  logic              phase_off_s;
  logic [ICNT_W-1:0] idle_cnt_s;
  logic              sec_clr_s;
  logic              pulse_s;
  logic              enter_set_s;

  // Helpers
  logic              rise_s;
  logic [HCNT_W-1:0] hold_inc_s;
  logic [BCNT_W-1:0] blink_inc_s;
  logic [ICNT_W-1:0] idle_inc_s;

  assign rise_s      = up_btn & ~up_prev_r;
  assign hold_inc_s  = hold_cnt_r + HCNT_W'(1'b1);
  assign blink_inc_s = blink_cnt_r + BCNT_W'(1'b1);
  assign idle_inc_s  = idle_cnt_r + ICNT_W'(1'b1);

  // Mode FSM next state, increment generation and the idle timeout; the
  // input priority is mode_btn > sel_btn > up_btn.
  always_comb begin
    state_s     = state_r;
    armed_s     = armed_r;
    rep_phase_s = rep_phase_r;
    hold_cnt_s  = hold_cnt_r;
    idle_cnt_s  = idle_cnt_r;
    sec_clr_s   = 1'b0;
    pulse_s     = 1'b0;
    enter_set_s = 1'b0;
    case (state_r)
      ST_RUN: begin
        armed_s     = 1'b0;
        rep_phase_s = 1'b0;
        hold_cnt_s  = '0;
        idle_cnt_s  = '0;
        if (mode_btn) begin
          state_s     = ST_SET_MIN;
          sec_clr_s   = 1'b1;
          enter_set_s = 1'b1;
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_SET_MIN, ST_SET_HOUR: begin
        if (mode_btn) begin
          state_s     = ST_RUN;
          armed_s     = 1'b0;
          rep_phase_s = 1'b0;
          hold_cnt_s  = '0;
          idle_cnt_s  = '0;
        end else if (sel_btn) begin
          // A field change while the key is held disarms it until the key is pressed again.
          state_s     = (state_r == ST_SET_MIN) ? ST_SET_HOUR : ST_SET_MIN;
          enter_set_s = 1'b1;
          armed_s     = 1'b0;
          rep_phase_s = 1'b0;
          hold_cnt_s  = '0;
          idle_cnt_s  = '0;
        end else if (up_btn) begin
          idle_cnt_s = '0;
          if (rise_s) begin
            pulse_s     = 1'b1;
            armed_s     = 1'b1;
            rep_phase_s = 1'b0;
            hold_cnt_s  = '0;
          end else if (armed_r) begin
            if (rep_phase_r) begin
              if (hold_inc_s == REPEAT_LAST) begin
                pulse_s    = 1'b1;
                hold_cnt_s = '0;
              end else begin
                hold_cnt_s = hold_inc_s;
              end
            end else begin
              if (hold_inc_s == HOLD_LAST) begin
                pulse_s     = 1'b1;
                rep_phase_s = 1'b1;
                hold_cnt_s  = '0;
              end else begin
                hold_cnt_s = hold_inc_s;
              end
            end
          end else begin
            armed_s     = 1'b0;
            rep_phase_s = 1'b0;
            hold_cnt_s  = '0;
          end
        end else begin
          // Releasing the key clears the hold counter.
          armed_s     = 1'b0;
          rep_phase_s = 1'b0;
          hold_cnt_s  = '0;
          if (tick_1hz) begin
            if (idle_inc_s == TIMEOUT_LAST) begin
              state_s    = ST_RUN;
              idle_cnt_s = '0;
            end else begin
              idle_cnt_s = idle_inc_s;
            end
          end else begin
            idle_cnt_s = idle_cnt_r;
          end
        end
      end
      default: begin
        state_s     = ST_RUN;
        armed_s     = 1'b0;
        rep_phase_s = 1'b0;
        hold_cnt_s  = '0;
        idle_cnt_s  = '0;
      end
    endcase
  end

  // Blink phase: it restarts "on" whenever a field is entered or adjusted, and it is parked in RUN.
  always_comb begin
    blink_cnt_s = blink_cnt_r;
    phase_off_s = phase_off_r;
    if (state_s == ST_RUN) begin
      blink_cnt_s = '0;
      phase_off_s = 1'b0;
    end else if (enter_set_s || pulse_s) begin
      blink_cnt_s = '0;
      phase_off_s = 1'b0;
    end else if (blink_inc_s == BLINK_LAST) begin
      blink_cnt_s = '0;
      phase_off_s = ~phase_off_r;
    end else begin
      blink_cnt_s = blink_inc_s;
      phase_off_s = phase_off_r;
    end
  end

  // State, counters and registered outputs, with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_RUN;
      up_prev_r    <= 1'b0;
      armed_r      <= 1'b0;
      rep_phase_r  <= 1'b0;
      hold_cnt_r   <= '0;
      blink_cnt_r  <= '0;
      phase_off_r  <= 1'b0;
      idle_cnt_r   <= '0;
      run_en_r     <= 1'b1;
      sec_clr_r    <= 1'b0;
      inc_min_r    <= 1'b0;
      inc_hour_r   <= 1'b0;
      blank_min_r  <= 1'b0;
      blank_hour_r <= 1'b0;
    end else begin
      state_r      <= state_s;
      up_prev_r    <= up_btn;
      armed_r      <= armed_s;
      rep_phase_r  <= rep_phase_s;
      hold_cnt_r   <= hold_cnt_s;
      blink_cnt_r  <= blink_cnt_s;
      phase_off_r  <= phase_off_s;
      idle_cnt_r   <= idle_cnt_s;
      run_en_r     <= (state_s == ST_RUN);
      sec_clr_r    <= sec_clr_s;
      inc_min_r    <= pulse_s & (state_s == ST_SET_MIN);
      inc_hour_r   <= pulse_s & (state_s == ST_SET_HOUR);
      blank_min_r  <= phase_off_s & (state_s == ST_SET_MIN);
      blank_hour_r <= phase_off_s & (state_s == ST_SET_HOUR);
    end
  end

  assign state      = state_r;
  assign run_en     = run_en_r;
  assign sec_clr    = sec_clr_r;
  assign inc_min    = inc_min_r;
  assign inc_hour   = inc_hour_r;
  assign blank_min  = blank_min_r;
  assign blank_hour = blank_hour_r;

endmodule

// File: doc/clock_set_ctrl.md
Name: clock_set_ctrl

Overview:
Mode/time-setting sequencer for the digital clock datapath (sec/min/hour counters, 7-seg decoders). Owns the RUN / SET_MIN / SET_HOUR state and produces:
- count enable for the seconds chain
- seconds clear on entry to set mode
- single-cycle minute/hour increment pulses, with press-and-hold auto-repeat
- blink blanking controls for the digit pair being set
- auto-return to RUN after an idle timeout

Parameters:
HOLD_CYC, 50000000, clk cycles up_btn must stay held after the first increment before auto-repeat starts (min 2)
REPEAT_CYC, 10000000, clk cycles between auto-repeat increments (min 2)
BLINK_CYC, 25000000, clk cycles per blink half-period (min 1)
TIMEOUT_S, 30, tick_1hz pulses with no button activity in a SET state before forced return to RUN (min 1)

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
tick_1hz  input  1  one-cycle pulse at 1 Hz from the prescaler
mode_btn  input  1  debounced one-cycle press pulse, mode key
sel_btn  input  1  debounced one-cycle press pulse, field-select key
up_btn  input  1  debounced level, high while up key held
run_en  output  1  high = seconds chain may count
sec_clr  output  1  one-cycle pulse, clear seconds counters
inc_min  output  1  one-cycle pulse, advance minutes by 1
inc_hour  output  1  one-cycle pulse, advance hours by 1
blank_min  output  1  high = blank minute digits (blink off-phase)
blank_hour  output  1  high = blank hour digits
state  output  2  00 RUN, 01 SET_MIN, 10 SET_HOUR (11 unused, recovers to RUN)

Behaviour:
- All outputs registered. Reset value:
  - state = RUN, run_en = 1
  - sec_clr, inc_min, inc_hour, blank_min, blank_hour = 0
  - all internal counters = 0, blink phase = on, up_btn history = 0
- Reset wins over all inputs in the same cycle. Reset asserted mid-hold or mid-SET returns to RUN next cycle with no increment pulse.
- Input priority in one cycle: mode_btn > sel_btn > up_btn.
- State transitions (visible one cycle after the input is sampled):
  - RUN + mode_btn -> SET_MIN; sec_clr = 1 in that same cycle.
  - SET_MIN / SET_HOUR + mode_btn -> RUN.
  - SET_MIN + sel_btn -> SET_HOUR; SET_HOUR + sel_btn -> SET_MIN.
  - sel_btn is ignored in RUN. up_btn is ignored in RUN: no pulses, repeat counter held at 0.
  - Illegal state 11 -> RUN.
- run_en = 1 only in RUN.
- Increment generation (SET states only):
  - up_btn rising edge sampled at edge n -> inc pulse high during cycle n+1, for exactly 1 cycle. The hold counter starts at that point.
  - Held continuously for HOLD_CYC cycles after the first pulse -> second pulse. Then one pulse every REPEAT_CYC cycles while still held.
  - Release clears the hold counter.
  - Pulse routes to inc_min in SET_MIN and to inc_hour in SET_HOUR.
  - A state change (sel_btn or mode_btn) while held clears the hold counter and suppresses pulses until up_btn is released and pressed again.
  - inc_min and inc_hour are never high together.
  - Wrap-around of the minute/hour values is the datapath's job, not this block's.
- Blink:
  - Phase register toggles every BLINK_CYC cycles while in a SET state.
  - Phase forced to "on" (and its counter cleared) on entry to any SET state and on every inc pulse, so the field stays visible while adjusting.
  - blank_min = (state==SET_MIN) & phase_off. blank_hour = (state==SET_HOUR) & phase_off.
  - Both blank outputs are 0 in RUN.
- Timeout:
  - Idle counter increments on tick_1hz while in a SET state.
  - Cleared by any mode_btn, sel_btn, up_btn high level, or entry to a SET state.
  - On reaching TIMEOUT_S -> RUN next cycle, counter cleared, no sec_clr.
  - tick_1hz coincident with a button event: the clear wins.
- sec_clr only on RUN -> SET_MIN. Never on SET -> RUN.

Test Plan:
Use HOLD_CYC=8, REPEAT_CYC=4, BLINK_CYC=3, TIMEOUT_S=5.
1. Reset/entry: rst 1 cycle, then mode_btn pulse -> state 01, run_en 0, sec_clr high exactly 1 cycle; second mode_btn -> state 00, run_en 1, no sec_clr.
2. Single press: in SET_MIN, up_btn high 3 cycles -> exactly one inc_min pulse, 1 cycle after rise; inc_hour stays 0.
3. Hold/repeat: in SET_HOUR, up_btn held 20 cycles -> inc_hour pulses at offsets 1, 9, 13, 17 from the rise (4 pulses); release -> no further pulses.
4. Blink: idle in SET_MIN -> blank_min pattern 0,0,0,1,1,1,0… with period 6; blank_hour 0 throughout; an inc_min pulse restarts the pattern at 0; blank_min 0 in RUN.
5. Priority/select: mode_btn and sel_btn in the same cycle in SET_MIN -> RUN. sel_btn in RUN -> state unchanged. sel_btn while up_btn held in SET_MIN -> SET_HOUR with no inc pulses until up_btn is re-pressed.
6. Timeout: enter SET_MIN, 4 tick_1hz pulses, then up press (resets idle count), then 5 more ticks -> RUN one cycle after the 5th tick, sec_clr 0. rst during a SET state -> RUN next cycle.
